// File: rtl/note_sequencer_pkg.sv
// note_seq_pkg: shared definitions for the note sequencer.
//   state_e      - internal FSM states (PLAY, RECORD, FETCH, HOLD)
//   MODE_*       - encodings reported on the mode output
//   pack_event() - builds an event word {note, dur} for any KEYS/DUR_W up
//                  to PACK_W bits total; callers cast the result down.
package note_seq_pkg;

  typedef enum logic [1:0] {
    ST_PLAY   = 2'd0,
    ST_RECORD = 2'd1,
    ST_FETCH  = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_PLAY     = 2'd0;
  localparam logic [1:0] MODE_RECORD   = 2'd1;
  localparam logic [1:0] MODE_PLAYBACK = 2'd2;

  localparam int PACK_W = 64;

  // Note sits above the duration field; both inputs arrive zero-extended.
  function automatic logic [PACK_W-1:0] pack_event(input logic [PACK_W-1:0] note,
                                                   input logic [PACK_W-1:0] dur,
                                                   input int                dur_w);
    return (note << dur_w) | dur;
  endfunction

endpackage

// File: rtl/note_sequencer_seq_ram.sv
// seq_ram: simple dual-port event memory shared by all tracks.
//   clk      - clock
//   we_i     - write enable, waddr_i / wdata_i written on the rising edge
//   re_i     - read enable, rdata_o valid the cycle after raddr_i is presented
// No reset so the array maps onto block RAM.
module seq_ram #(
  parameter int AW = 10,
  parameter int DW = 22
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: live note pass-through, multi-track event recorder and
// once/looped playback with the replayed notes OR-ed onto the live keys.
//   clk, rst       - clock, asynchronous active-low reset
//   note_in        - live key vector
//   btn_rec        - pulse: start/stop recording on track_sel
//   btn_play       - pulse: start/abort playback of track_sel
//   loop           - at end of track, 1 restarts from event 0
//   track_sel      - track for the next record/playback start
//   note_out       - registered note vector
//   mode           - 0 PLAY, 1 RECORD, 2 PLAYBACK
//   full           - sticky, last recording ran out of track space
//   cur_len        - stored event count of track_sel
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter  int KEYS     = 10,
  parameter  int DEPTH    = 256,
  parameter  int TRACKS   = 4,
  parameter  int DUR_W    = 12,
  parameter  int TICK_DIV = 500000,
  localparam int TW       = (TRACKS > 1) ? $clog2(TRACKS) : 1,
  localparam int LW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KEYS-1:0] note_in,
  input  logic            btn_rec,
  input  logic            btn_play,
  input  logic            loop,
  input  logic [TW-1:0]   track_sel,
  output logic [KEYS-1:0] note_out,
  output logic [1:0]      mode,
  output logic            full,
  output logic [LW-1:0]   cur_len
);

  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW    = TW + PW;
  localparam int EW    = KEYS + DUR_W;
  localparam int PRE_W = $clog2(TICK_DIV);

  localparam logic [DUR_W-1:0] DUR_MAX   = '1;
  localparam logic [DUR_W-1:0] DUR_TOP1  = DUR_MAX - 1'b1;
  localparam logic [LW-1:0]    LEN_FULL  = LW'(DEPTH);
  localparam logic [LW-1:0]    WPTR_LAST = LW'(DEPTH - 1);
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);

  state_e            state_q, state_d;
  logic              fph_q, fph_d;       // FETCH phase: 0 read issued, 1 data valid
  logic [TW-1:0]     trk_q, trk_d;
  logic [LW-1:0]     wptr_q, wptr_d;
  logic [LW-1:0]     rptr_q, rptr_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic [KEYS-1:0]   last_q, last_d;
  logic [KEYS-1:0]   play_q, play_d;
  logic [KEYS-1:0]   note_q, note_d;
  logic              full_q, full_d;
  logic [PRE_W-1:0]  pre_q;
  logic              pre_clr, tick;
  logic [LW-1:0]     len_q [2**TW];
  logic              len_we;
  logic [TW-1:0]     len_wtrk;
  logic [LW-1:0]     len_wval;

  logic              wr_en, rd_en;
  logic [DUR_W-1:0]  wr_dur;
  logic [EW-1:0]     wr_data, rd_data;
  logic [KEYS-1:0]   rd_note;
  logic [DUR_W-1:0]  rd_dur;

  assign rd_note = rd_data[EW-1:DUR_W];
  assign rd_dur  = rd_data[DUR_W-1:0];
  assign wr_data = EW'(pack_event(PACK_W'(last_q), PACK_W'(wr_dur), DUR_W));

  seq_ram #(.AW(AW), .DW(EW)) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i ({trk_q, wptr_q[PW-1:0]}),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i ({trk_q, rptr_q[PW-1:0]}),
    .rdata_o (rd_data)
  );

  // Duration prescaler, free running apart from the clears requested by the FSM.
  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                pre_q <= '0;
    else if (pre_clr || tick) pre_q <= '0;
    else                     pre_q <= pre_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2**TW; i++) len_q[i] <= '0;
    end else if (len_we) begin
      len_q[len_wtrk] <= len_wval;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_PLAY;
      fph_q   <= 1'b0;
      trk_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      dur_q   <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      play_q  <= '0;
      note_q  <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fph_q   <= fph_d;
      trk_q   <= trk_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dur_q   <= dur_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      play_q  <= play_d;
      note_q  <= note_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    fph_d    = fph_q;
    trk_d    = trk_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    dur_d    = dur_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    play_d   = play_q;
    full_d   = full_q;
    note_d   = note_in;
    pre_clr  = 1'b0;
    wr_en    = 1'b0;
    wr_dur   = dur_q;
    rd_en    = 1'b0;
    len_we   = 1'b0;
    len_wtrk = trk_q;
    len_wval = wptr_q;

    case (state_q)
      ST_PLAY: begin
        if (btn_rec) begin
          state_d  = ST_RECORD;
          trk_d    = track_sel;
          wptr_d   = '0;
          dur_d    = '0;
          last_d   = note_in;
          full_d   = 1'b0;
          len_we   = 1'b1;
          len_wtrk = track_sel;
          len_wval = '0;
          pre_clr  = 1'b1;
        end else if (btn_play && (len_q[track_sel] != '0)) begin
          state_d = ST_FETCH;
          fph_d   = 1'b0;
          trk_d   = track_sel;
          rptr_d  = '0;
          play_d  = '0;
          pre_clr = 1'b1;
        end
      end

      ST_RECORD: begin
        if (btn_rec) begin
          // Flush the note still being held, then commit the length.
          wr_en    = (dur_q != '0);
          len_we   = 1'b1;
          len_wval = wptr_q + LW'(wr_en);
          state_d  = ST_PLAY;
        end else if (note_in != last_q) begin
          // A value that never saw a tick is a glitch and is dropped.
          wr_en  = (dur_q != '0);
          last_d = note_in;
          dur_d  = '0;
        end else if (tick) begin
          if (dur_q == DUR_TOP1) begin
            // Duration saturates: emit a full-length event, same note carries on.
            wr_en  = 1'b1;
            wr_dur = DUR_MAX;
            dur_d  = '0;
          end else begin
            dur_d = dur_q + 1'b1;
          end
        end
        if (wr_en) begin
          wptr_d = wptr_q + 1'b1;
          if (wptr_q == WPTR_LAST) begin
            full_d   = 1'b1;
            len_we   = 1'b1;
            len_wval = LEN_FULL;
            state_d  = ST_PLAY;
          end
        end
      end

      ST_FETCH: begin
        note_d = play_q | note_in;
        if (btn_play) begin
          note_d  = note_in;
          fph_d   = 1'b0;
          state_d = ST_PLAY;
        end else if (!fph_q) begin
          rd_en = 1'b1;
          fph_d = 1'b1;
        end else begin
          // Forward the fresh note straight to the output register.
          cnt_d   = rd_dur;
          play_d  = rd_note;
          note_d  = rd_note | note_in;
          fph_d   = 1'b0;
          state_d = ST_HOLD;
        end
      end

      ST_HOLD: begin
        note_d = play_q | note_in;
        if (btn_play) begin
          note_d  = note_in;
          state_d = ST_PLAY;
        end else if ((cnt_q == '0) || (tick && (cnt_q == DUR_W'(1)))) begin
          cnt_d = '0;
          if (({1'b0, rptr_q} + 1'b1) < {1'b0, len_q[trk_q]}) begin
            rptr_d  = rptr_q + 1'b1;
            state_d = ST_FETCH;
          end else if (loop) begin
            rptr_d  = '0;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_PLAY;
          end
        end else if (tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_PLAY;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_RECORD:         mode = MODE_RECORD;
      ST_FETCH, ST_HOLD: mode = MODE_PLAYBACK;
      default:           mode = MODE_PLAY;
    endcase
  end

  assign note_out = note_q;
  assign full     = full_q;
  assign cur_len  = len_q[track_sel];

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Parametrised multi-track note recorder/sequencer between the debounced keyboard front end and the MIDI/I2S output path. It passes live notes through, records note-change events with tick-quantised durations into per-track memory, and replays a track once or looped. During playback the replayed notes are overlaid on the live keys.

## Interface
- KEYS, 10, width of the one-hot/multi-hot note vector
- DEPTH, 256, events per track
- TRACKS, 4, number of independent tracks
- DUR_W, 12, duration field width in ticks
- TICK_DIV, 500000, clk cycles per duration tick (≥2)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- note_in  in  KEYS  live key vector, synchronous to clk
- btn_rec  in  1  single-cycle pulse: start/stop recording
- btn_play  in  1  single-cycle pulse: start/abort playback
- loop  in  1  sampled at end of track: 1 = restart from event 0
- track_sel  in  max(1,$clog2(TRACKS))  track for the next record/playback, sampled only on the starting pulse
- note_out  out  KEYS  registered note vector to the synth/MIDI path
- mode  out  2  0 PLAY, 1 RECORD, 2 PLAYBACK
- full  out  1  sticky: last recording hit DEPTH
- cur_len  out  $clog2(DEPTH+1)  stored length of the track selected by track_sel

## Operation
- States: PLAY, RECORD, FETCH, HOLD. mode reports FETCH/HOLD as PLAYBACK.
- Event word = {note[KEYS-1:0], dur[DUR_W-1:0]}. Per-track length register len[t].
- Prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick at wrap. It is cleared on entry to RECORD and FETCH-from-PLAY.
- PLAY: note_out <= note_in. btn_rec -> RECORD, btn_play -> FETCH only if len[track_sel]≠0, otherwise ignored. Simultaneous btn_rec and btn_play: btn_rec wins.
- RECORD entry: latch track, wptr=0, dur=0, last=note_in, full=0, len[track]=0. note_out <= note_in.
- RECORD, each cycle:
  - tick increments dur.
  - When note_in≠last: if dur≠0, write {last,dur} at wptr and increment wptr; if dur=0, discard the event (glitch filter). In both cases last=note_in and dur=0.
  - dur reaching all-ones: write {last,max} and reset dur to 0. The same note continues as the next event.
- RECORD exit: btn_rec flushes {last,dur} if dur≠0, sets len[track]=wptr, and goes to PLAY. btn_play is ignored.
- Full: a write with wptr=DEPTH-1 sets full, commits len=DEPTH, and goes to PLAY.
- FETCH: issue a read at {track,rptr}. Data is valid the next cycle, then go to HOLD with cnt=dur and play_note=note.
- HOLD: note_out <= play_note | note_in. tick decrements cnt. When cnt reaches 0:
  - if rptr+1<len, increment rptr and go to FETCH;
  - else if loop, set rptr=0 and go to FETCH;
  - else go to PLAY.
- btn_play during FETCH/HOLD aborts to PLAY. btn_rec is ignored during playback.
- Reset mid-operation: all state is lost, len[] is cleared to 0, and memory contents become don't-care.

## Timing
- Reset values: note_out=0, mode=0, full=0, cur_len=0. All len[]=0, state PLAY, prescaler 0.
- PLAY/RECORD pass-through: note_out follows note_in with 1-cycle latency.
- Playback start: btn_play sampled at edge k gives FETCH at k+1, read data at k+2, and the first stored note on note_out at edge k+3.
- Inter-event gap: FETCH adds 2 cycles per event. Each event lasts dur ticks plus 2 cycles plus prescaler phase.
- Write latency: memory write occurs on the edge following change detection.
- cur_len is combinational from len[track_sel]. Its update becomes visible the cycle after RECORD exit.

## Structure
- Package note_seq_pkg holds:
  - state encoding constants (PLAY=0, RECORD=1, PLAYBACK=2 for mode, plus internal FETCH/HOLD);
  - the event-word packing helper.
- Sub-module seq_ram:
  - simple dual-port, TRACKS*DEPTH × (KEYS+DUR_W);
  - synchronous write, registered read with 1-cycle latency;
  - no reset, so it infers block RAM.
- Top holds FSM, prescaler, len[] array, and the output register.

## Test plan
- Reset: hold rst low for 3 cycles with note_in=10'h3FF -> note_out=0, mode=0, cur_len=0. After release, note_out=10'h3FF one cycle later.
- Record/replay, TICK_DIV=4, track 1: hold notes 0x001 for 3 ticks, 0x004 for 2 ticks, then btn_rec -> cur_len=2. Playback then outputs 0x001 for 12+2 cycles and 0x004 for 8+2 cycles, then mode returns to 0.
- Glitch filter: note_in changes twice within one tick -> no event is written for the transient value, and len is unchanged by the glitch.
- Full, DEPTH=4: toggle the note every tick -> full=1 after the 4th write, mode=0, cur_len=4.
- Loop and overlay: loop=1 on a 2-event track with note_in=0x200 held -> note_out=stored|0x200, and it repeats event 0 after event 1. btn_play aborts to mode=0 within 1 cycle.
- Arbitration: btn_rec and btn_play asserted together in PLAY -> mode=1. btn_play in an empty track -> stays in mode 0.
